// File: rtl/axi_slave_mem.sv
// AXI4 slave memory responder: word-addressed RAM behind AW/W/B/AR/R with FIXED/INCR/WRAP bursts.
// Optional macro AXI_SLV_BACKPRESSURE_EN adds LFSR-driven ready/valid stalls.
module axi_slave_mem #(
  parameter int          ID_W      = 4,
  parameter int          ADDR_W    = 16,
  parameter int          DATA_W    = 64,
  parameter int          MEM_WORDS = 1024,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_WORDS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    case (len)
      8'd1, 8'd3, 8'd7, 8'd15: wrap_len_ok = 1'b1;
      default:                 wrap_len_ok = 1'b0;
    endcase
  endfunction

  function automatic logic burst_err(input logic [1:0] burst, input logic [7:0] len);
    case (burst)
      BURST_FIXED, BURST_INCR: burst_err = 1'b0;
      BURST_WRAP:              burst_err = !wrap_len_ok(len);
      default:                 burst_err = 1'b1;
    endcase
  endfunction

  // Illegal WRAP lengths and the reserved burst type fall back to INCR stepping.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                input logic [7:0] len,
                                                input logic [1:0] burst);
    logic [IDX_W-1:0] inc;
    logic [IDX_W-1:0] mask;
    inc  = idx + IDX_W'(1);
    mask = IDX_W'(len);
    case (burst)
      BURST_FIXED: next_idx = idx;
      BURST_WRAP: begin
        if (wrap_len_ok(len)) next_idx = (idx & ~mask) | (inc & mask);
        else                  next_idx = inc;
      end
      default: next_idx = inc;
    endcase
  endfunction

  logic rdy_gate_s;
  logic raise_ok_s;

`ifdef AXI_SLV_BACKPRESSURE_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Fibonacci LFSR next state, taps 16/14/13/11
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // LFSR register, free-running
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end

  // Readies are registered, so they are gated by the value the LFSR takes next cycle.
  assign rdy_gate_s = lfsr_d[0];
  assign raise_ok_s = lfsr_q[1];
`else
  assign rdy_gate_s = 1'b1;
  assign raise_ok_s = 1'b1;
`endif

  logic [DATA_W-1:0] mem_q [MEM_WORDS];
  logic [DATA_W-1:0] ram_rd_q;

  // ---------------- write path ----------------
  w_state_e         w_state_q, w_state_d;
  logic [ID_W-1:0]  w_id_q, w_id_d;
  logic [IDX_W-1:0] w_idx_q, w_idx_d;
  logic [7:0]       w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [1:0]       w_burst_q, w_burst_d;
  logic             w_err_q, w_err_d;
  logic             awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [ID_W-1:0]  bid_q, bid_d;
  logic [1:0]       bresp_q, bresp_d;
  logic             mem_we_s;

  // Write FSM next state and registered AW/W/B outputs
  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_burst_d = w_burst_q;
    w_err_d   = w_err_q;
    mem_we_s  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (awvalid && awready_q) begin
          w_id_d    = awid;
          w_idx_d   = awaddr[LSB +: IDX_W];
          w_len_d   = awlen;
          w_burst_d = awburst;
          w_cnt_d   = 8'd0;
          w_err_d   = burst_err(awburst, awlen);
          w_state_d = W_DATA;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_DATA: begin
        if (wvalid && wready_q) begin
          mem_we_s = 1'b1;
          if (wlast != (w_cnt_q == w_len_q)) w_err_d = 1'b1;
          else                               w_err_d = w_err_q;
          if (w_cnt_q == w_len_q) begin
            w_state_d = W_RESP;
          end else begin
            w_cnt_d = w_cnt_q + 8'd1;
            w_idx_d = next_idx(w_idx_q, w_len_q, w_burst_q);
          end
        end else begin
          w_state_d = W_DATA;
        end
      end
      W_RESP: begin
        if (bready) w_state_d = W_IDLE;
        else        w_state_d = W_RESP;
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) && rdy_gate_s;
    wready_d  = (w_state_d == W_DATA) && rdy_gate_s;
    bvalid_d  = (w_state_d == W_RESP);
    if (bvalid_d) begin
      bid_d   = w_id_d;
      bresp_d = w_err_d ? RESP_SLVERR : RESP_OKAY;
    end else begin
      bid_d   = {ID_W{1'b0}};
      bresp_d = RESP_OKAY;
    end
  end

  // Write FSM and write-side output registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      w_id_q    <= {ID_W{1'b0}};
      w_idx_q   <= {IDX_W{1'b0}};
      w_len_q   <= 8'd0;
      w_cnt_q   <= 8'd0;
      w_burst_q <= 2'b00;
      w_err_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= {ID_W{1'b0}};
      bresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_burst_q <= w_burst_d;
      w_err_q   <= w_err_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  // ---------------- read path ----------------
  // Two stages: RAM output (ram_rd_q/ram_vld_q) feeds the R output register.
  r_state_e          r_state_q, r_state_d;
  logic [ID_W-1:0]   r_id_q, r_id_d;
  logic [IDX_W-1:0]  r_idx_q, r_idx_d;
  logic [7:0]        r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [1:0]        r_burst_q, r_burst_d;
  logic              r_err_q, r_err_d, r_done_q, r_done_d;
  logic              ram_vld_q, ram_vld_d, ram_last_q, ram_last_d;
  logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              out_free_s, load_s, r_issue_s;

  // Read FSM next state, RAM issue control and R output staging
  always_comb begin
    r_state_d  = r_state_q;
    r_id_d     = r_id_q;
    r_idx_d    = r_idx_q;
    r_len_d    = r_len_q;
    r_cnt_d    = r_cnt_q;
    r_burst_d  = r_burst_q;
    r_err_d    = r_err_q;
    r_done_d   = r_done_q;
    ram_vld_d  = ram_vld_q;
    ram_last_d = ram_last_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    rdata_d    = rdata_q;
    rid_d      = rid_q;
    rresp_d    = rresp_q;
    out_free_s = !rvalid_q || rready;
    load_s     = out_free_s && ram_vld_q && raise_ok_s;
    r_issue_s  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (arvalid && arready_q) begin
          r_id_d    = arid;
          r_idx_d   = araddr[LSB +: IDX_W];
          r_len_d   = arlen;
          r_burst_d = arburst;
          r_err_d   = burst_err(arburst, arlen);
          r_cnt_d   = 8'd0;
          r_done_d  = 1'b0;
          r_state_d = R_DATA;
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_DATA: begin
        r_issue_s = !r_done_q && (!ram_vld_q || load_s);
        if (rvalid_q && rready && rlast_q) r_state_d = R_IDLE;
        else                               r_state_d = R_DATA;
      end
      default: r_state_d = R_IDLE;
    endcase
    if (r_issue_s) begin
      ram_vld_d  = 1'b1;
      ram_last_d = (r_cnt_q == r_len_q);
      if (r_cnt_q == r_len_q) begin
        r_done_d = 1'b1;
      end else begin
        r_cnt_d = r_cnt_q + 8'd1;
        r_idx_d = next_idx(r_idx_q, r_len_q, r_burst_q);
      end
    end else if (load_s) begin
      ram_vld_d = 1'b0;
    end else begin
      ram_vld_d = ram_vld_q;
    end
    if (load_s) begin
      rvalid_d = 1'b1;
      rdata_d  = ram_rd_q;
      rlast_d  = ram_last_q;
      rid_d    = r_id_q;
      rresp_d  = r_err_q ? RESP_SLVERR : RESP_OKAY;
    end else if (out_free_s) begin
      rvalid_d = 1'b0;
      rlast_d  = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end
    arready_d = (r_state_d == R_IDLE) && rdy_gate_s;
  end

  // Read FSM and read-side output registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q  <= R_IDLE;
      r_id_q     <= {ID_W{1'b0}};
      r_idx_q    <= {IDX_W{1'b0}};
      r_len_q    <= 8'd0;
      r_cnt_q    <= 8'd0;
      r_burst_q  <= 2'b00;
      r_err_q    <= 1'b0;
      r_done_q   <= 1'b0;
      ram_vld_q  <= 1'b0;
      ram_last_q <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rdata_q    <= {DATA_W{1'b0}};
      rid_q      <= {ID_W{1'b0}};
      rresp_q    <= 2'b00;
    end else begin
      r_state_q  <= r_state_d;
      r_id_q     <= r_id_d;
      r_idx_q    <= r_idx_d;
      r_len_q    <= r_len_d;
      r_cnt_q    <= r_cnt_d;
      r_burst_q  <= r_burst_d;
      r_err_q    <= r_err_d;
      r_done_q   <= r_done_d;
      ram_vld_q  <= ram_vld_d;
      ram_last_q <= ram_last_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rdata_q    <= rdata_d;
      rid_q      <= rid_d;
      rresp_q    <= rresp_d;
    end
  end

  // RAM: byte-strobed write port, read-first synchronous read port (contents never reset)
  always_ff @(posedge aclk) begin
    if (mem_we_s) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem_q[w_idx_q][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (r_issue_s) ram_rd_q <= mem_q[r_idx_q];
  end

  logic unused_addr_bits_s;
  assign unused_addr_bits_s = ^{awaddr[LSB-1:0], awaddr[ADDR_W-1:LSB+IDX_W],
                                araddr[LSB-1:0], araddr[ADDR_W-1:LSB+IDX_W]};

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rdata   = rdata_q;
  assign rid     = rid_q;
  assign rresp   = rresp_q;

endmodule
